// File: rtl/sensor_debouncer_if.sv
// Signal bundle between the raw irrigation-station switches and the conditioned
// levels consumed by the error, alarm, valve and 7-segment logic.
interface sensor_debouncer_if;
  logic high_raw;
  logic middle_raw;
  logic low_raw;
  logic umidadeDoSolo_raw;
  logic umidadeDoAr_raw;
  logic temperatura_raw;
  logic sel_btn_raw;

  logic high;
  logic middle;
  logic low;
  logic umidadeDoSolo;
  logic umidadeDoAr;
  logic temperatura;
  logic seletor;
  logic update;

  // master: switch side driving raw levels; slave: the debouncer.
  modport master (
    output high_raw, middle_raw, low_raw,
    output umidadeDoSolo_raw, umidadeDoAr_raw, temperatura_raw, sel_btn_raw,
    input  high, middle, low, umidadeDoSolo, umidadeDoAr, temperatura,
    input  seletor, update
  );

  modport slave (
    input  high_raw, middle_raw, low_raw,
    input  umidadeDoSolo_raw, umidadeDoAr_raw, temperatura_raw, sel_btn_raw,
    output high, middle, low, umidadeDoSolo, umidadeDoAr, temperatura,
    output seletor, update
  );
endinterface

// File: rtl/sensor_debouncer.sv
// Seven-channel synchronizer + debouncer for the irrigation station inputs,
// plus the toggle that turns the select button into a persistent display selector.
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk,
  input  logic               rst_n,
  sensor_debouncer_if.slave  bus
);

  localparam int NCH  = 7;
  localparam int SENS = 6;
  localparam int BTN  = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_param
    $error("sensor_debouncer: DEBOUNCE_CYCLES out of range");
  end

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1_q, s1_d;
  logic [NCH-1:0]   s2_q, s2_d;
  logic [NCH-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic             seletor_q, seletor_d;
  logic             update_q, update_d;

  // Bit order: sensors first (0..5), button last, so update can OR the low slice.
  assign raw = {bus.sel_btn_raw,
                bus.temperatura_raw,
                bus.umidadeDoAr_raw,
                bus.umidadeDoSolo_raw,
                bus.low_raw,
                bus.middle_raw,
                bus.high_raw};

  always_comb begin
    s1_d      = raw;
    s2_d      = s1_q;
    stable_d  = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      // Any sample matching the accepted level restarts the qualification run.
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    update_d  = |(stable_d[SENS-1:0] ^ stable_q[SENS-1:0]);
    seletor_d = seletor_q ^ (stable_d[BTN] & ~stable_q[BTN]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      seletor_q <= 1'b0;
      update_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      seletor_q <= seletor_d;
      update_q  <= update_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.high          = stable_q[0];
  assign bus.middle        = stable_q[1];
  assign bus.low           = stable_q[2];
  assign bus.umidadeDoSolo = stable_q[3];
  assign bus.umidadeDoAr   = stable_q[4];
  assign bus.temperatura   = stable_q[5];
  assign bus.seletor       = seletor_q;
  assign bus.update        = update_q;

endmodule

// File: tb/tb_sensor_debouncer.sv
// Directed bench for sensor_debouncer: window-based reference model checked every
// cycle, plus hand-computed latency/width/selector expectations.
module tb_sensor_debouncer;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] raw_v = '0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  sensor_debouncer_if bus ();

  assign bus.high_raw          = raw_v[0];
  assign bus.middle_raw        = raw_v[1];
  assign bus.low_raw           = raw_v[2];
  assign bus.umidadeDoSolo_raw = raw_v[3];
  assign bus.umidadeDoAr_raw   = raw_v[4];
  assign bus.temperatura_raw   = raw_v[5];
  assign bus.sel_btn_raw       = raw_v[6];

  sensor_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wire [7:0] dut_o = {bus.update, bus.seletor, bus.temperatura, bus.umidadeDoAr,
                      bus.umidadeDoSolo, bus.low, bus.middle, bus.high};

  // Reference model: a level is accepted once the last N synchronized samples
  // (raw delayed by two edges) all disagree with the currently accepted level.
  logic [N:0] hist [7];
  logic [6:0] m_stable = '0;
  logic       m_sel = 1'b0;
  logic       m_upd = 1'b0;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [6:0] nxt;
    if (!rst_n) begin
      for (int ch = 0; ch < 7; ch++) hist[ch] <= '0;
      m_stable <= '0;
      m_sel    <= 1'b0;
      m_upd    <= 1'b0;
      m_valid  <= 1'b1;
    end else begin
      nxt = m_stable;
      for (int ch = 0; ch < 7; ch++) begin
        if (hist[ch][N:1] == {N{~m_stable[ch]}}) nxt[ch] = ~m_stable[ch];
        hist[ch] <= {hist[ch][N-1:0], raw_v[ch]};
      end
      m_upd    <= |(nxt[5:0] ^ m_stable[5:0]);
      m_sel    <= m_sel ^ (nxt[6] & ~m_stable[6]);
      m_stable <= nxt;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (dut_o !== {m_upd, m_sel, m_stable[5:0]}) begin
        failures++;
        $display("FAIL model_cmp t=%0t dut=%b expected=%b", $time, dut_o,
                 {m_upd, m_sel, m_stable[5:0]});
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int   hi_cnt;
    int   upd_cnt;
    int   rise_a;
    int   rise_b;
    logic seen_low;
    logic seen_upd;

    // Reset values, all raw high during reset.
    raw_v = 7'h3F;
    rst_n = 1'b0;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(1);
    chk("reset_first_cycle", dut_o, 8'h00);
    wait_n(16);
    chk("reset_edge17", dut_o, 8'h00);
    wait_n(1);
    chk("reset_edge18", dut_o, 8'hBF);
    wait_n(1);
    chk("reset_edge19", dut_o, 8'h3F);

    // Latency on a middle step.
    raw_v = '0;
    wait_n(40);
    raw_v[1] = 1'b1;
    wait_n(17);
    chk("middle_edge17", 8'(bus.middle), 8'h00);
    wait_n(1);
    chk("middle_edge18", 8'(bus.middle), 8'h01);
    wait_n(30);

    // 15-cycle pulse is filtered.
    seen_low = 1'b0;
    seen_upd = 1'b0;
    raw_v[2] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen_low |= bus.low;
      seen_upd |= bus.update;
    end
    raw_v[2] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_low |= bus.low;
      seen_upd |= bus.update;
    end
    chk("low15_output", 8'(seen_low), 8'h00);
    chk("low15_update", 8'(seen_upd), 8'h00);

    // 16-cycle pulse passes with its width preserved.
    hi_cnt  = 0;
    upd_cnt = 0;
    raw_v[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      hi_cnt  += int'(bus.low);
      upd_cnt += int'(bus.update);
    end
    raw_v[2] = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      hi_cnt  += int'(bus.low);
      upd_cnt += int'(bus.update);
    end
    chk("low16_width", 8'(hi_cnt), 8'd16);
    chk("low16_updates", 8'(upd_cnt), 8'd2);

    // Bounce on temperatura: 1 (10), 0 (10), then hold 1.
    upd_cnt = 0;
    rise_a  = 0;
    raw_v[5] = 1'b1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); upd_cnt += int'(bus.update); end
    raw_v[5] = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); upd_cnt += int'(bus.update); end
    raw_v[5] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      upd_cnt += int'(bus.update);
      if (bus.temperatura && rise_a == 0) rise_a = i;
    end
    chk("bounce_rise", 8'(rise_a), 8'd18);
    chk("bounce_updates", 8'(upd_cnt), 8'd1);

    // Selector: press, release, press again, short press.
    raw_v[6] = 1'b1;
    wait_n(17);
    chk("sel_press1_edge17", 8'(bus.seletor), 8'h00);
    wait_n(1);
    chk("sel_press1_edge18", 8'(bus.seletor), 8'h01);
    wait_n(22);
    raw_v[6] = 1'b0;
    wait_n(40);
    chk("sel_after_release1", 8'(bus.seletor), 8'h01);
    raw_v[6] = 1'b1;
    wait_n(40);
    raw_v[6] = 1'b0;
    wait_n(40);
    chk("sel_after_press2", 8'(bus.seletor), 8'h00);
    raw_v[6] = 1'b1;
    wait_n(10);
    raw_v[6] = 1'b0;
    wait_n(40);
    chk("sel_short_press", 8'(bus.seletor), 8'h00);

    // Simultaneous high and umidadeDoAr step.
    upd_cnt = 0;
    rise_a  = 0;
    rise_b  = 0;
    raw_v[0] = 1'b1;
    raw_v[4] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      upd_cnt += int'(bus.update);
      if (bus.high && rise_a == 0) rise_a = i;
      if (bus.umidadeDoAr && rise_b == 0) rise_b = i;
    end
    chk("simul_high_rise", 8'(rise_a), 8'd18);
    chk("simul_ar_rise", 8'(rise_b), 8'd18);
    chk("simul_updates", 8'(upd_cnt), 8'd1);

    // Reset in the middle of a soil-humidity qualification run.
    raw_v[3] = 1'b1;
    wait_n(10);
    rst_n = 1'b0;
    wait_n(1);
    chk("midreset_cleared", dut_o, 8'h00);
    rst_n = 1'b1;
    wait_n(17);
    chk("midreset_edge17", 8'(bus.umidadeDoSolo), 8'h00);
    wait_n(1);
    chk("midreset_edge18", 8'(bus.umidadeDoSolo), 8'h01);
    wait_n(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
